parity_stream_unit: RTL and testbench
=====================================

Name: parity_stream_unit

Overview:
Parametrised streaming parity generator/checker. Computes per-word parity over WIDTH-bit data words accepted on a valid/ready input and forwards each word with its parity bit through a registered output stage. In check mode it compares against a received parity bit. It also accumulates frame-level parity and error status over FRAME_LEN words and keeps a saturating error count. Sits between a data source and downstream serial/link logic in lab datapaths.

Parameters:
WIDTH, 4, data word width in bits (>=1)
FRAME_LEN, 8, words per frame (>=1)
ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (parity bit = inverted XOR)
CNT_W, 8, error counter width

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous reset, active-high
mode  in  1  0 = generate, 1 = check; sampled on the first word of each frame
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
in_data  in  WIDTH  input word
in_par  in  1  received parity bit; used only in check mode
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the output word
out_data  out  WIDTH  forwarded word
out_par  out  1  computed parity bit
out_err  out  1  word parity mismatch (check mode only, else 0)
frame_done  out  1  one-cycle pulse: last word of a frame accepted
frame_par  out  1  parity over all WIDTH*FRAME_LEN frame bits (ODD applied once); valid with frame_done
frame_err  out  1  OR of out_err over the frame; valid with frame_done
err_cnt  out  CNT_W  saturating count of word errors since reset

Behaviour:
- Reset: in_ready=1; out_valid=0; out_data=0; out_par=0; out_err=0; frame_done=0; frame_par=0; frame_err=0; err_cnt=0; word index=0; frame mode register=0; FSM=IDLE.
- Accept: a word is accepted when in_valid&in_ready. in_ready = !out_valid | out_ready (combinational; the output register accepts a new word in the same cycle it is drained).
- Output stage latency is 1 cycle: an accepted word appears on out_* on the next cycle with out_valid=1. out_* are held stable while out_valid&!out_ready. out_valid clears when the word is drained and no new word is accepted in that cycle.
- Parity: p = XOR(in_data) ^ ODD. out_par = p. out_err = frame_mode & (p != in_par).
- FSM has two states:
  - IDLE (word index 0): an accepted word latches frame_mode = mode, starts the accumulator with XOR(in_data) and the error-OR with that word's error, then goes to RUN. If FRAME_LEN=1, the frame completes immediately and the FSM stays in IDLE.
  - RUN: each accepted word XORs into the accumulator, ORs its error and increments the index. When the word with index FRAME_LEN-1 is accepted, the index wraps to 0 and the FSM returns to IDLE.
- Mode changes during RUN are ignored until the next frame starts.
- frame_done asserts for exactly one cycle, in the same cycle the last word's out_* first become valid. It carries frame_par = accumulator ^ ODD and frame_err, both including the last word. frame_par and frame_err hold their values until the next frame_done.
- err_cnt increments by 1 per accepted erroring word and saturates at 2^CNT_W-1. Frame completion does not clear it.
- Simultaneous drain and accept: the output register loads the new word with no bubble. Full throughput is 1 word/cycle.
- Reset mid-frame: the partial frame is discarded and no frame_done is produced. Any held output word is dropped and all state returns to its reset value.
- No accept occurs while rst=1.

Test Plan:
- Gen, even (WIDTH=4, ODD=0): in_data=4'b1011 with out_ready=1 -> next cycle out_valid=1, out_data=4'b1011, out_par=1, out_err=0.
- Odd parity (ODD=1): in_data=4'b0110 -> out_par=1; in_data=4'b0111 -> out_par=0.
- Check mode: mode=1, in_data=4'b1011, in_par=0 -> out_err=1 and err_cnt goes 0 to 1. Then in_data=4'b0011, in_par=0 -> out_err=0 and err_cnt stays 1.
- Frame (FRAME_LEN=8, gen): 8 back-to-back words, 7 with parity 0 and 1 with parity 1 -> a single frame_done pulse coincident with the 8th out_valid, frame_par=1, frame_err=0; index wraps and the 9th word starts a new frame.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first word; out_data held constant; no extra accepts. After out_ready=1, words drain in order with no loss or duplication.
- Reset mid-frame: accept 3 words, assert rst for 1 cycle, then send 8 words -> exactly one frame_done, after the 8th post-reset word; err_cnt=0 after reset; out_valid=0 during the reset cycle.

Source files
------------

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker with a one-word output register.
// Also tracks frame-level parity/error over FRAME_LEN words and a saturating error count.
module parity_stream_unit #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int ODD       = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_err,
    output logic             frame_done,
    output logic             frame_par,
    output logic             frame_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int              IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic             ODD_BIT  = (ODD != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic word_parity(input logic [WIDTH-1:0] d);
        return (^d) ^ ODD_BIT;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             acc_q, acc_d;
    logic             ferr_q, ferr_d;
    logic             fmode_q, fmode_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_par_q, out_par_d;
    logic             out_err_q, out_err_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_par_q, frame_par_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept_s;
    logic             mode_eff_s;
    logic             word_par_s;
    logic             word_err_s;
    logic             last_s;
    logic             acc_in_s;
    logic             ferr_in_s;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready && !rst;

    // First word of a frame uses the live mode input; later words use the latched one.
    assign mode_eff_s = (state_q == ST_IDLE) ? mode : fmode_q;
    assign word_par_s = word_parity(in_data);
    assign word_err_s = mode_eff_s && (word_par_s != in_par);
    assign last_s     = (idx_q == LAST_IDX);
    assign acc_in_s   = (state_q == ST_IDLE) ? (^in_data) : (acc_q ^ (^in_data));
    assign ferr_in_s  = (state_q == ST_IDLE) ? word_err_s : (ferr_q || word_err_s);

    // Frame FSM: word index, running parity, error-OR and latched mode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ferr_d  = ferr_q;
        fmode_d = fmode_q;
        if (accept_s) begin
            acc_d  = acc_in_s;
            ferr_d = ferr_in_s;
            case (state_q)
                ST_IDLE: begin
                    fmode_d = mode;
                    if (last_s) begin
                        state_d = ST_IDLE;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        state_d = ST_RUN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        state_d = ST_IDLE;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        state_d = ST_RUN;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register, frame status and saturating error counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_par_d    = out_par_q;
        out_err_d    = out_err_q;
        frame_done_d = 1'b0;
        frame_par_d  = frame_par_q;
        frame_err_d  = frame_err_q;
        err_cnt_d    = err_cnt_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_par_d   = word_par_s;
            out_err_d   = word_err_s;
            if (last_s) begin
                frame_done_d = 1'b1;
                frame_par_d  = acc_in_s ^ ODD_BIT;
                frame_err_d  = ferr_in_s;
            end else begin
                frame_done_d = 1'b0;
            end
            if (word_err_s && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IDX_W{1'b0}};
            acc_q        <= 1'b0;
            ferr_q       <= 1'b0;
            fmode_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {WIDTH{1'b0}};
            out_par_q    <= 1'b0;
            out_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_par_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            ferr_q       <= ferr_d;
            fmode_q      <= fmode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_par_q    <= out_par_d;
            out_err_q    <= out_err_d;
            frame_done_q <= frame_done_d;
            frame_par_q  <= frame_par_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_par    = out_par_q;
    assign out_err    = out_err_q;
    assign frame_done = frame_done_q;
    assign frame_par  = frame_par_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Bench for parity_stream_unit: directed vector table, hand sequences and random traffic
// against a word-list reference model, on an even/FRAME_LEN=8 and an odd/FRAME_LEN=3 instance.
module tb_parity_stream_unit;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_par;
    logic       out_ready;

    logic       rdy0, ov0, op0, oe0, fd0, fp0, fe0;
    logic [3:0] od0;
    logic [7:0] cnt0;
    logic       rdy1, ov1, op1, oe1, fd1, fp1, fe1;
    logic [3:0] od1;
    logic [1:0] cnt1;

    parity_stream_unit #(.WIDTH(4), .FRAME_LEN(8), .ODD(0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_par(in_par), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_par(op0), .out_err(oe0), .frame_done(fd0),
        .frame_par(fp0), .frame_err(fe0), .err_cnt(cnt0)
    );

    parity_stream_unit #(.WIDTH(4), .FRAME_LEN(3), .ODD(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_par(in_par), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_par(op1), .out_err(oe1), .frame_done(fd1),
        .frame_par(fp1), .frame_err(fe1), .err_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rdy[2], d_ov[2], d_op[2], d_oe[2], d_fd[2], d_fp[2], d_fe[2];
    logic [3:0] d_od[2];
    logic [7:0] d_cnt[2];
    assign d_rdy[0] = rdy0; assign d_rdy[1] = rdy1;
    assign d_ov[0]  = ov0;  assign d_ov[1]  = ov1;
    assign d_op[0]  = op0;  assign d_op[1]  = op1;
    assign d_oe[0]  = oe0;  assign d_oe[1]  = oe1;
    assign d_fd[0]  = fd0;  assign d_fd[1]  = fd1;
    assign d_fp[0]  = fp0;  assign d_fp[1]  = fp1;
    assign d_fe[0]  = fe0;  assign d_fe[1]  = fe1;
    assign d_od[0]  = od0;  assign d_od[1]  = od1;
    assign d_cnt[0] = cnt0; assign d_cnt[1] = {6'b0, cnt1};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each instance keeps the words of the current frame as a list.
    int         FL[2]   = '{8, 3};
    int         OD[2]   = '{0, 1};
    int         CMAX[2] = '{255, 3};
    bit         m_live;
    bit         m_ov[2], m_op[2], m_oe[2], m_fd[2], m_fp[2], m_fe[2], m_fmode[2];
    logic [3:0] m_od[2];
    int         m_cnt[2];
    int         m_nw[2];
    logic [3:0] m_words[2][8];
    bit         m_errs[2][8];

    function automatic int ones(input logic [3:0] d);
        int n = 0;
        for (int b = 0; b < 4; b++) n += int'(d[b]);
        return n;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s u%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_clock(input bit r, input bit m, input bit v, input logic [3:0] d,
                               input bit p_in, input bit rd);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_ov[k] = 0; m_od[k] = 4'd0; m_op[k] = 0; m_oe[k] = 0; m_fd[k] = 0;
                m_fp[k] = 0; m_fe[k] = 0; m_cnt[k] = 0; m_nw[k] = 0; m_fmode[k] = 0;
            end else begin
                bit acc = v && (!m_ov[k] || rd);
                m_fd[k] = 0;
                if (acc) begin
                    bit p;
                    bit e;
                    if (m_nw[k] == 0) m_fmode[k] = m;
                    p = bit'(ones(d) % 2) ^ bit'(OD[k]);
                    e = m_fmode[k] && (p != p_in);
                    m_ov[k] = 1; m_od[k] = d; m_op[k] = p; m_oe[k] = e;
                    m_words[k][m_nw[k]] = d;
                    m_errs[k][m_nw[k]]  = e;
                    m_nw[k]++;
                    if (e && m_cnt[k] < CMAX[k]) m_cnt[k]++;
                    if (m_nw[k] == FL[k]) begin
                        int tot = 0;
                        bit any = 0;
                        for (int w = 0; w < FL[k]; w++) begin
                            tot += ones(m_words[k][w]);
                            any |= m_errs[k][w];
                        end
                        m_fd[k] = 1;
                        m_fp[k] = bit'(tot % 2) ^ bit'(OD[k]);
                        m_fe[k] = any;
                        m_nw[k] = 0;
                    end
                end else if (rd) begin
                    m_ov[k] = 0;
                end
            end
        end
        if (r) m_live = 1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, int'(d_ov[k]), int'(m_ov[k]));
            if (m_ov[k]) begin
                chk("out_data", k, int'(d_od[k]), int'(m_od[k]));
                chk("out_par", k, int'(d_op[k]), int'(m_op[k]));
                chk("out_err", k, int'(d_oe[k]), int'(m_oe[k]));
            end
            chk("frame_done", k, int'(d_fd[k]), int'(m_fd[k]));
            chk("frame_par", k, int'(d_fp[k]), int'(m_fp[k]));
            chk("frame_err", k, int'(d_fe[k]), int'(m_fe[k]));
            chk("err_cnt", k, int'(d_cnt[k]), m_cnt[k]);
        end
    endtask

    // One clock: drive at the falling edge, check in_ready, clock, check outputs at next fall.
    task automatic step(input bit r, input bit m, input bit v, input logic [3:0] d,
                        input bit p, input bit rd);
        rst = r; mode = m; in_valid = v; in_data = d; in_par = p; out_ready = rd;
        #1;
        if (m_live) begin
            for (int k = 0; k < 2; k++)
                chk("in_ready", k, int'(d_rdy[k]), int'(!m_ov[k] || rd));
        end
        model_clock(r, m, v, d, p, rd);
        @(posedge clk);
        @(negedge clk);
        if (m_live) check_all();
    endtask

    typedef struct {
        bit         rst, mode, vld;
        logic [3:0] data;
        bit         par, rdy;
        bit         e_ov;
        logic [3:0] e_od;
        bit         e_op, e_oe, e_fd, e_fp, e_fe;
        int         e_cnt;
    } vec_t;

    vec_t tbl[19];
    int   nfd;

    initial begin
        m_live = 0;
        rst = 1; mode = 0; in_valid = 0; in_data = 4'd0; in_par = 0; out_ready = 1;
        @(negedge clk);
        step(1, 0, 0, 4'd0, 0, 1);
        step(1, 0, 0, 4'd0, 0, 1);
        chk("reset_out_valid", 0, int'(ov0), 0);
        chk("reset_in_ready", 0, int'(rdy0), 1);
        chk("reset_out_data", 0, int'(od0), 0);
        chk("reset_err_cnt", 0, int'(cnt0), 0);

        //        rst mode vld data    par rdy | ov od      op oe fd fp fe cnt
        tbl[0]  = '{0, 0, 1, 4'b1011, 0, 1,  1, 4'b1011, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 4'b0000, 1, 1,  1, 4'b0000, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 4'b0011, 1, 1,  1, 4'b0011, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 4'b0101, 0, 1,  1, 4'b0101, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 4'b0110, 1, 1,  1, 4'b0110, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 4'b1001, 0, 1,  1, 4'b1001, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 4'b1111, 1, 1,  1, 4'b1111, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 4'b1100, 0, 1,  1, 4'b1100, 0, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 1, 4'b1011, 0, 1,  1, 4'b1011, 1, 1, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 1, 4'b0011, 0, 1,  1, 4'b0011, 0, 0, 0, 1, 0, 1};
        tbl[10] = '{0, 1, 0, 4'b0000, 0, 1,  0, 4'b0011, 0, 0, 0, 1, 0, 1};
        tbl[11] = '{0, 0, 1, 4'b0001, 1, 1,  1, 4'b0001, 1, 0, 0, 1, 0, 1};
        tbl[12] = '{0, 0, 1, 4'b0001, 0, 1,  1, 4'b0001, 1, 1, 0, 1, 0, 2};
        tbl[13] = '{0, 0, 1, 4'b1111, 0, 1,  1, 4'b1111, 0, 0, 0, 1, 0, 2};
        tbl[14] = '{0, 0, 1, 4'b1110, 1, 1,  1, 4'b1110, 1, 0, 0, 1, 0, 2};
        tbl[15] = '{0, 0, 1, 4'b0000, 0, 1,  1, 4'b0000, 0, 0, 0, 1, 0, 2};
        tbl[16] = '{0, 0, 1, 4'b0111, 0, 1,  1, 4'b0111, 1, 1, 1, 1, 1, 3};
        tbl[17] = '{0, 0, 1, 4'b0101, 1, 1,  1, 4'b0101, 0, 0, 0, 1, 1, 3};
        tbl[18] = '{1, 0, 1, 4'b1111, 0, 1,  0, 4'b0000, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].mode, tbl[i].vld, tbl[i].data, tbl[i].par, tbl[i].rdy);
            chk("tbl_out_valid", i, int'(ov0), int'(tbl[i].e_ov));
            if (tbl[i].e_ov || tbl[i].rst) chk("tbl_out_data", i, int'(od0), int'(tbl[i].e_od));
            if (tbl[i].e_ov) begin
                chk("tbl_out_par", i, int'(op0), int'(tbl[i].e_op));
                chk("tbl_out_err", i, int'(oe0), int'(tbl[i].e_oe));
            end
            chk("tbl_frame_done", i, int'(fd0), int'(tbl[i].e_fd));
            chk("tbl_frame_par", i, int'(fp0), int'(tbl[i].e_fp));
            chk("tbl_frame_err", i, int'(fe0), int'(tbl[i].e_fe));
            chk("tbl_err_cnt", i, int'(cnt0), tbl[i].e_cnt);
        end

        // Odd-parity instance.
        step(0, 0, 1, 4'b0110, 0, 1);
        chk("odd_par_0110", 1, int'(op1), 1);
        step(0, 0, 1, 4'b0111, 0, 1);
        chk("odd_par_0111", 1, int'(op1), 0);

        // Backpressure: A accepted, B held by the source through three stalled cycles.
        step(0, 0, 1, 4'b1010, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 4'b0101, 0, 0);
            chk("bp_in_ready", 0, int'(rdy0), 0);
            chk("bp_held_data", 0, int'(od0), 4'b1010);
        end
        step(0, 0, 1, 4'b0101, 0, 1);
        chk("bp_release_data", 0, int'(od0), 4'b0101);
        step(0, 0, 0, 4'b0000, 0, 1);
        chk("bp_drained", 0, int'(ov0), 0);

        // Reset mid-frame: errors before reset, then one clean frame of eight words.
        step(1, 0, 0, 4'd0, 0, 1);
        step(0, 1, 1, 4'b0001, 0, 1);
        step(0, 1, 1, 4'b0011, 0, 1);
        step(0, 1, 1, 4'b0111, 0, 1);
        chk("pre_reset_cnt", 0, int'(cnt0), 2);
        step(1, 0, 1, 4'b1111, 0, 1);
        chk("reset_mid_ov", 0, int'(ov0), 0);
        chk("reset_mid_cnt", 0, int'(cnt0), 0);
        nfd = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, (i < 8), 4'(i + 3), 0, 1);
            chk("post_reset_fd", i, int'(fd0), (i == 7) ? 1 : 0);
            nfd += int'(fd0);
        end
        chk("post_reset_fd_count", 0, nfd, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) == 0), bit'($urandom_range(1)),
                 ($urandom_range(3) != 0), 4'($urandom_range(15)),
                 bit'($urandom_range(1)), ($urandom_range(3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
